// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: off/on/blink/breathe per channel, driven from one
// shared timebase (tick prescaler, blink phase, triangle duty ramp + PWM).

module led_pattern_ch #(
   parameter bit ACT_LO = 1'b1
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       wr_en,
   input  logic [1:0] wr_mode,
   input  logic       blink_phase,
   input  logic       pwm_on,
   output logic       led
);
   localparam logic [1:0] MODE_ON      = 2'd1;
   localparam logic [1:0] MODE_BLINK   = 2'd2;
   localparam logic [1:0] MODE_BREATHE = 2'd3;

   logic [1:0] mode_q, mode_d;
   logic       led_q, led_d;
   logic       on;

   always_comb begin
      mode_d = wr_en ? wr_mode : mode_q;
      on     = (mode_q == MODE_ON)
             | ((mode_q == MODE_BLINK) & blink_phase)
             | ((mode_q == MODE_BREATHE) & pwm_on);
      led_d  = on ^ ACT_LO;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mode_q <= 2'd0;
         led_q  <= ACT_LO;
      end else begin
         mode_q <= mode_d;
         led_q  <= led_d;
      end
   end

   assign led = led_q;
endmodule

module led_pattern_gen #(
   parameter int NUM_LEDS       = 3,
   parameter int TICK_DIV       = 27000,
   parameter int BLINK_TICKS    = 500,
   parameter int PWM_W          = 8,
   parameter int LED_ACTIVE_LOW = 1,
   localparam int CH_W          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   output logic [NUM_LEDS-1:0] led,
   output logic                tick
);
   localparam int TC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BC_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [TC_W-1:0]  TICK_LAST  = TC_W'(TICK_DIV - 1);
   localparam logic [BC_W-1:0]  BLINK_LAST = BC_W'(BLINK_TICKS - 1);
   localparam logic [PWM_W-1:0] DUTY_MAX   = '1;
   localparam bit               ACT_LO     = (LED_ACTIVE_LOW != 0);

   typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

   logic [TC_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic             tick_q, tick_d;
   logic [BC_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic             blink_phase_q, blink_phase_d;
   logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_W-1:0] duty_q, duty_d;
   dir_e             dir_q, dir_d;
   logic             tick_en;
   logic             pwm_on;

   // tick_en marks the edge on which the registered tick rises; every
   // timebase update happens on that same edge.
   always_comb begin
      tick_en       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d    = tick_en ? '0 : tick_cnt_q + TC_W'(1);
      tick_d        = tick_en;
      pwm_cnt_d     = pwm_cnt_q + PWM_W'(1);
      pwm_on        = (pwm_cnt_q < duty_q);
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      duty_d        = duty_q;
      dir_d         = dir_q;
      if (tick_en) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BC_W'(1);
         end
         // Triangle ramp turns around immediately so each extreme lasts one tick.
         if (dir_q == DIR_UP) begin
            if (duty_q == DUTY_MAX) begin
               dir_d  = DIR_DOWN;
               duty_d = DUTY_MAX - PWM_W'(1);
            end else begin
               duty_d = duty_q + PWM_W'(1);
            end
         end else begin
            if (duty_q == '0) begin
               dir_d  = DIR_UP;
               duty_d = PWM_W'(1);
            end else begin
               duty_d = duty_q - PWM_W'(1);
            end
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tick_cnt_q    <= '0;
         tick_q        <= 1'b0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         pwm_cnt_q     <= '0;
         duty_q        <= '0;
         dir_q         <= DIR_UP;
      end else begin
         tick_cnt_q    <= tick_cnt_d;
         tick_q        <= tick_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         pwm_cnt_q     <= pwm_cnt_d;
         duty_q        <= duty_d;
         dir_q         <= dir_d;
      end
   end

   assign tick = tick_q;

   // Out-of-range channel indices match no lane, so such writes drop silently.
   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_pattern_ch #(.ACT_LO(ACT_LO)) u_ch (
         .sys_clk     (sys_clk),
         .sys_rst_n   (sys_rst_n),
         .wr_en       (cfg_we && (cfg_ch == CH_W'(i))),
         .wr_mode     (cfg_mode),
         .blink_phase (blink_phase_q),
         .pwm_on      (pwm_on),
         .led         (led[i])
      );
   end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with TICK_DIV=8, BLINK_TICKS=2, PWM_W=3.

module tb_led_pattern_gen;
   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_ch = 2'd0;
   logic [1:0] cfg_mode = 2'd0;
   logic [2:0] led;
   logic       tick;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   led_pattern_gen #(
      .NUM_LEDS(3), .TICK_DIV(8), .BLINK_TICKS(2), .PWM_W(3), .LED_ACTIVE_LOW(1)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_mode(cfg_mode), .led(led), .tick(tick)
   );

   always #5 sys_clk = ~sys_clk;

   // One active edge, then park on the following negedge for sampling/driving.
   task automatic step();
      @(posedge sys_clk);
      @(negedge sys_clk);
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      cfg_we = 1'b0;
      sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic write(input logic [1:0] ch, input logic [1:0] mode);
      cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if (led !== 3'b111 || tick !== 1'b0) begin
         errors++; $display("FAIL reset_state: led=%b tick=%b, expected led=111 tick=0", led, tick);
      end
      do_reset();
      repeat (100) begin
         step();
         checks++;
         if (led !== 3'b111) begin
            errors++; $display("FAIL idle_led: cyc %0d led=%b expected 111", cyc, led);
         end
         checks++;
         if (tick !== ((cyc % 8) == 0)) begin
            errors++; $display("FAIL idle_tick: cyc %0d tick=%b expected %b", cyc, tick, (cyc % 8) == 0);
         end
      end
   endtask

   task automatic test_static();
      do_reset();
      repeat (3) step();
      write(2'd1, 2'd1);
      checks++;
      if (led !== 3'b111) begin
         errors++; $display("FAIL static_latency: led=%b expected 111", led);
      end
      step();
      checks++;
      if (led !== 3'b101) begin
         errors++; $display("FAIL static_on: led=%b expected 101", led);
      end
      repeat (5) step();
      write(2'd1, 2'd0);
      checks++;
      if (led !== 3'b101) begin
         errors++; $display("FAIL static_off_latency: led=%b expected 101", led);
      end
      step();
      checks++;
      if (led !== 3'b111) begin
         errors++; $display("FAIL static_off: led=%b expected 111", led);
      end
   endtask

   task automatic test_blink();
      logic exp0;
      do_reset();
      write(2'd0, 2'd2);
      while (cyc < 80) begin
         step();
         // blink_phase toggles on edges 16, 32, ...; led lags by one edge
         exp0 = (((cyc - 1) / 16) % 2) == 0;
         checks++;
         if (led !== {2'b11, exp0}) begin
            errors++; $display("FAIL blink: cyc %0d led=%b expected %b", cyc, led, {2'b11, exp0});
         end
      end
   endtask

   task automatic test_breathe();
      int exp_duty [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
      int lows;
      do_reset();
      write(2'd2, 2'd3);
      while (cyc < 8) step();
      for (int k = 0; k < 16; k++) begin
         lows = 0;
         repeat (8) begin
            step();
            if (led[2] == 1'b0) lows++;
         end
         checks++;
         if (lows !== exp_duty[k]) begin
            errors++; $display("FAIL breathe_duty: window %0d low=%0d expected %0d", k + 1, lows, exp_duty[k]);
         end
      end
   endtask

   task automatic test_invalid_simul();
      logic exp1;
      do_reset();
      write(2'd3, 2'd1);
      step();
      checks++;
      if (led !== 3'b111) begin
         errors++; $display("FAIL invalid_ch: led=%b expected 111", led);
      end
      do_reset();
      write(2'd0, 2'd2);
      write(2'd1, 2'd2);
      while (cyc < 15) step();
      write(2'd0, 2'd0);
      while (cyc < 64) begin
         step();
         exp1 = (((cyc - 1) / 16) % 2) == 0;
         checks++;
         if (led[1] !== exp1) begin
            errors++; $display("FAIL simul_blink_ch1: cyc %0d led1=%b expected %b", cyc, led[1], exp1);
         end
         checks++;
         if (led[0] !== 1'b1) begin
            errors++; $display("FAIL simul_off_ch0: cyc %0d led0=%b expected 1", cyc, led[0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      write(2'd2, 2'd3);
      write(2'd0, 2'd1);
      while (cyc < 43) step();
      checks++;
      if (led[0] !== 1'b0) begin
         errors++; $display("FAIL pre_reset_on: led0=%b expected 0", led[0]);
      end
      #2;
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if (led !== 3'b111 || tick !== 1'b0) begin
         errors++; $display("FAIL async_reset: led=%b tick=%b expected 111/0", led, tick);
      end
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      cyc = 0;
      repeat (40) begin
         step();
         checks++;
         if (led !== 3'b111) begin
            errors++; $display("FAIL post_reset_dark: cyc %0d led=%b expected 111", cyc, led);
         end
         if (cyc == 8) begin
            checks++;
            if (tick !== 1'b1) begin
               errors++; $display("FAIL post_reset_tick: tick=%b expected 1", tick);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_static();
      test_blink();
      test_breathe();
      test_invalid_simul();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Multi-channel LED driver that generates static, blink and breathe (triangle-ramped PWM) patterns. Each channel's pattern mode is set through a simple register-write port. One shared timebase serves all channels: a tick prescaler, a blink phase and a breathe duty ramp. The block sits between the top-level control logic and the board LED pins, and generalises the single fixed-rate blinker.

Parameters:
NUM_LEDS, 3, number of LED channels (>=1).
TICK_DIV, 27000, sys_clk cycles per timebase tick (>=1); 27000 gives 1 kHz at 27 MHz.
BLINK_TICKS, 500, ticks per blink half-period (>=1).
PWM_W, 8, width of the PWM counter and duty (>=2).
LED_ACTIVE_LOW, 1, 1 = pin driven 0 to light the LED.
CH_W (localparam), max(1, clog2(NUM_LEDS)), width of the channel select.

Ports:
sys_clk  in  1  system clock.
sys_rst_n  in  1  asynchronous active-low reset.
cfg_we  in  1  mode write strobe, sampled each rising edge.
cfg_ch  in  CH_W  channel index for the write.
cfg_mode  in  2  mode: 0 off, 1 on, 2 blink, 3 breathe.
led  out  NUM_LEDS  registered LED pin drive.
tick  out  1  one-cycle timebase tick pulse, for status/debug.

Behaviour:
- One clock domain, sys_clk. Reset is asynchronous, active-low, and applied through sys_rst_n.
- Reset values:
  - All mode registers = 0 (off).
  - tick_cnt = 0, blink_cnt = 0, blink_phase = 0.
  - pwm_cnt = 0, duty = 0, dir = up.
  - tick = 0.
  - led = all LED_ACTIVE_LOW (every LED dark).
- Reset asserted mid-operation forces these values immediately, regardless of clock.
- Prescaler:
  - tick_cnt counts 0..TICK_DIV-1, then wraps to 0.
  - tick is registered and equals 1 for exactly the cycle after tick_cnt = TICK_DIV-1.
  - TICK_DIV=1 gives tick high continuously.
- Blink:
  - On each tick, if blink_cnt = BLINK_TICKS-1, blink_cnt returns to 0 and blink_phase toggles; otherwise blink_cnt increments.
  - Half-period = TICK_DIV*BLINK_TICKS cycles.
- PWM:
  - pwm_cnt is a free-running PWM_W-bit counter, incrementing every cycle and wrapping from 2^PWM_W-1 to 0.
  - pwm_on = (pwm_cnt < duty). duty=0 gives always off; duty=max gives on for 2^PWM_W-1 of every 2^PWM_W cycles.
- Duty ramp (triangle), updated on tick only:
  - up: if duty = max, set dir=down and duty=max-1; else duty+1.
  - down: if duty = 0, set dir=up and duty=1; else duty-1.
  - No plateau: each extreme is held for exactly one tick.
- Config:
  - cfg_we high at edge k writes cfg_mode into mode[cfg_ch] at edge k.
  - Writes with cfg_ch >= NUM_LEDS are ignored; no other state changes.
  - No handshake; a write is accepted every cycle.
  - A write does not disturb the shared timebase.
- Output:
  - On each edge, led[i] <= on_i XOR LED_ACTIVE_LOW, where on_i = (mode[i]=1) | (mode[i]=2 & blink_phase) | (mode[i]=3 & pwm_on), using register values before the edge.
  - Latency: a write at edge k is visible on led at edge k+1.
  - A timebase change at edge k is visible on led at edge k+1.
- Channels are fully independent except for the shared timebase. Channels in the same mode are phase-locked.
- A write coinciding with a tick or a blink toggle: both take effect at the same edge.

Test Plan:
Common parameters for all scenarios: NUM_LEDS=3, TICK_DIV=8, BLINK_TICKS=2, PWM_W=3, LED_ACTIVE_LOW=1. With TICK_DIV=8 and PWM_W=3, the tick aligns with each PWM window.
1. Reset and idle: hold sys_rst_n=0, then release with no writes for 100 cycles -> led=3'b111 throughout; tick pulses every 8 cycles.
2. Static on/off: write ch1 mode1 at edge k -> led=3'b101 from edge k+1. Write ch1 mode0 at edge m -> led=3'b111 from edge m+1.
3. Blink: write ch0 mode2 immediately after reset -> blink_phase first goes 1 at the second tick (edge 16). led[0] goes 0 from edge 17 for 16 cycles, then 1 for 16 cycles, repeating.
4. Breathe: ch2 mode3 -> per 8-cycle window, led[2] is low for duty cycles. Observed duty sequence is 0,1,2,...,7,6,...,1,0,1,... with each value held one window and 7 appearing once per peak.
5. Invalid channel and simultaneity: cfg_ch=3, mode1 -> led unchanged. Write ch0 blink->off on the same edge that blink_phase toggles -> led[0]=1 at the next edge, and the blink timebase continues unperturbed (verified via a second channel in blink).
6. Reset mid-breathe: assert sys_rst_n=0 asynchronously mid-window -> led=3'b111 without waiting for a clock edge, and all modes read back as off. After release, all channels stay dark until rewritten.
